// File: rtl/bus_sequencer.sv
// bus_sequencer: splits each bus cycle into NUM_CHANNELS slots of SLOT_CLKS
// clocks. Each slot gets a one-hot select, a request-qualified strobe and a
// one-clock done pulse. The CPU slot (channel 0) also carries an I/O qualifier.
// Optional feature macro: BUS_SEQUENCER_CPU_CLK_EN adds the cpu_clk (phi2) output.
module bus_sequencer #(
  parameter int NUM_CHANNELS = 2,
  parameter int SLOT_CLKS    = 8,
  parameter int STROBE_START = 2,
  parameter int STROBE_CLKS  = 4,
  localparam int SW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                    clk16,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic                    cpu_io_hit,
  output logic [NUM_CHANNELS-1:0] select,
  output logic [NUM_CHANNELS-1:0] strobe,
  output logic [NUM_CHANNELS-1:0] done,
  output logic                    io_select,
  output logic [SW-1:0]           slot,
`ifdef BUS_SEQUENCER_CPU_CLK_EN
  output logic                    cpu_clk,
`endif
  output logic                    cycle_start
);

  localparam int PW       = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam int STB_LAST = STROBE_START + STROBE_CLKS - 1;

  // Reject parameter sets that would let the strobe spill into the next slot.
  generate
    if (STROBE_CLKS < 1 || STROBE_START < 0 ||
        STROBE_START + STROBE_CLKS > SLOT_CLKS) begin : g_bad_strobe
      $fatal(1, "bus_sequencer: strobe window does not fit in the slot");
    end
    if (NUM_CHANNELS < 2 || NUM_CHANNELS > 8) begin : g_bad_chan
      $fatal(1, "bus_sequencer: NUM_CHANNELS must be 2..8");
    end
  endgenerate

  // ST_IDLE covers the clock between reset release and the first slot-0 entry,
  // so that the first edge lands on slot 0 phase 0 rather than phase 1.
  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t                  r_state;
  logic [PW-1:0]           r_phase;
  logic [SW-1:0]           r_slot;
  logic                    r_grant;
  logic                    r_iohit;

  logic [PW-1:0]           w_nphase;
  logic [SW-1:0]           w_nslot;
  logic                    w_entry;
  logic                    w_grant;
  logic                    w_iohit;
  logic                    w_in_strb;
  logic                    w_last_strb;
  logic [NUM_CHANNELS-1:0] w_sel;

  // Next counter state plus the qualifiers that describe it. Requests and the
  // I/O hit are captured on the edge that enters phase 0 so the strobe can
  // start as early as phase 0.
  always_comb begin
    w_nphase = '0;
    w_nslot  = '0;
    if (r_state == ST_RUN) begin
      if (r_phase == PW'(SLOT_CLKS - 1)) begin
        w_nphase = '0;
        w_nslot  = (r_slot == SW'(NUM_CHANNELS - 1)) ? '0 : r_slot + 1'b1;
      end else begin
        w_nphase = r_phase + 1'b1;
        w_nslot  = r_slot;
      end
    end
    w_entry     = (w_nphase == '0);
    w_grant     = w_entry ? req[w_nslot] : r_grant;
    w_iohit     = (w_entry && w_nslot == '0) ? cpu_io_hit : r_iohit;
    w_in_strb   = (int'(w_nphase) >= STROBE_START) && (int'(w_nphase) <= STB_LAST);
    w_last_strb = (int'(w_nphase) == STB_LAST);
    w_sel          = '0;
    w_sel[w_nslot] = 1'b1;
  end

  // Counters and all registered outputs, aligned to the counter state.
  always_ff @(posedge clk16 or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_slot      <= '0;
      r_grant     <= 1'b0;
      r_iohit     <= 1'b0;
      select      <= '0;
      strobe      <= '0;
      done        <= '0;
      io_select   <= 1'b0;
      slot        <= '0;
      cycle_start <= 1'b0;
`ifdef BUS_SEQUENCER_CPU_CLK_EN
      cpu_clk     <= 1'b0;
`endif
    end else begin
      r_state     <= ST_RUN;
      r_phase     <= w_nphase;
      r_slot      <= w_nslot;
      r_grant     <= w_grant;
      r_iohit     <= w_iohit;
      select      <= w_sel;
      strobe      <= (w_grant && w_in_strb) ? w_sel : '0;
      done        <= (w_grant && w_last_strb) ? w_sel : '0;
      io_select   <= (w_nslot == '0) && w_iohit;
      slot        <= w_nslot;
      cycle_start <= w_entry && (w_nslot == '0);
`ifdef BUS_SEQUENCER_CPU_CLK_EN
      // phi2 follows the CPU slot's strobe window start to slot end, unqualified by req[0].
      cpu_clk     <= (w_nslot == '0) && (int'(w_nphase) >= STROBE_START);
`endif
    end
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: two instances (default and 4x4 configuration) checked each
// clock against a time-based model: clock k after release sits in phase
// k%SLOT_CLKS of slot (k/SLOT_CLKS)%NUM_CHANNELS.
module tb_bus_sequencer;

  logic       clk16 = 1'b0;
  logic       reset = 1'b1;
  logic       cpu_io_hit = 1'b0;
  logic [1:0] req_a = 2'b11;
  logic [3:0] req_b = 4'b1010;

  logic [1:0] sel_a, strb_a, done_a;
  logic       io_a, cs_a;
  logic [0:0] slot_a;
  logic [3:0] sel_b, strb_b, done_b;
  logic       io_b, cs_b;
  logic [1:0] slot_b;
`ifdef BUS_SEQUENCER_CPU_CLK_EN
  logic       phi_a, phi_b;
`endif

  int total = 0;
  int bad   = 0;

  // model state: clocks since release (-1 while idle/reset), per-slot grants
  int ka = -1, pa = 0, sa = 0;
  int kb = -1, pb = 0, sb = 0;
  bit ga [2];
  bit gb [4];
  bit ha, hb;

  always #5 clk16 = ~clk16;

  bus_sequencer u_dut_a (
    .clk16(clk16), .reset(reset), .req(req_a), .cpu_io_hit(cpu_io_hit),
    .select(sel_a), .strobe(strb_a), .done(done_a), .io_select(io_a),
    .slot(slot_a),
`ifdef BUS_SEQUENCER_CPU_CLK_EN
    .cpu_clk(phi_a),
`endif
    .cycle_start(cs_a)
  );

  bus_sequencer #(.NUM_CHANNELS(4), .SLOT_CLKS(4), .STROBE_START(1), .STROBE_CLKS(3)) u_dut_b (
    .clk16(clk16), .reset(reset), .req(req_b), .cpu_io_hit(cpu_io_hit),
    .select(sel_b), .strobe(strb_b), .done(done_b), .io_select(io_b),
    .slot(slot_b),
`ifdef BUS_SEQUENCER_CPU_CLK_EN
    .cpu_clk(phi_b),
`endif
    .cycle_start(cs_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare();
    logic [31:0] e_sel, e_stb, e_dn, e_io, e_slot, e_cs, e_phi;
    // default configuration: 2 x 8, strobe 2..5
    e_sel = 0; e_stb = 0; e_dn = 0; e_io = 0; e_slot = 0; e_cs = 0; e_phi = 0;
    if (ka >= 0) begin
      e_sel  = 32'd1 << sa;
      e_stb  = (ga[sa] && pa >= 2 && pa <= 5) ? e_sel : 0;
      e_dn   = (ga[sa] && pa == 5) ? e_sel : 0;
      e_io   = (sa == 0 && ha) ? 1 : 0;
      e_slot = sa;
      e_cs   = (ka % 16 == 0) ? 1 : 0;
      e_phi  = (sa == 0 && pa >= 2) ? 1 : 0;
    end
    chk("a_select", sel_a, e_sel);
    chk("a_strobe", strb_a, e_stb);
    chk("a_done", done_a, e_dn);
    chk("a_io_select", io_a, e_io);
    chk("a_slot", slot_a, e_slot);
    chk("a_cycle_start", cs_a, e_cs);
`ifdef BUS_SEQUENCER_CPU_CLK_EN
    chk("a_cpu_clk", phi_a, e_phi);
`endif
    // 4 x 4 configuration, strobe 1..3
    e_sel = 0; e_stb = 0; e_dn = 0; e_io = 0; e_slot = 0; e_cs = 0; e_phi = 0;
    if (kb >= 0) begin
      e_sel  = 32'd1 << sb;
      e_stb  = (gb[sb] && pb >= 1 && pb <= 3) ? e_sel : 0;
      e_dn   = (gb[sb] && pb == 3) ? e_sel : 0;
      e_io   = (sb == 0 && hb) ? 1 : 0;
      e_slot = sb;
      e_cs   = (kb % 16 == 0) ? 1 : 0;
      e_phi  = (sb == 0 && pb >= 1) ? 1 : 0;
    end
    chk("b_select", sel_b, e_sel);
    chk("b_strobe", strb_b, e_stb);
    chk("b_done", done_b, e_dn);
    chk("b_io_select", io_b, e_io);
    chk("b_slot", slot_b, e_slot);
    chk("b_cycle_start", cs_b, e_cs);
`ifdef BUS_SEQUENCER_CPU_CLK_EN
    chk("b_cpu_clk", phi_b, e_phi);
`endif
  endtask

  // advance one clock: capture inputs seen by the edge, update model, compare
  task automatic step();
    logic [1:0] ra;
    logic [3:0] rb;
    logic       io;
    ra = req_a; rb = req_b; io = cpu_io_hit;
    @(posedge clk16);
    #1;
    if (reset) begin
      ka = -1; kb = -1;
    end else begin
      ka++; pa = ka % 8; sa = (ka / 8) % 2;
      if (pa == 0) begin ga[sa] = ra[sa]; if (sa == 0) ha = io; end
      kb++; pb = kb % 4; sb = (kb / 4) % 4;
      if (pb == 0) begin gb[sb] = rb[sb]; if (sb == 0) hb = io; end
    end
    compare();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // step until instance A shows slot s phase p (and optionally a granted slot)
  task automatic wait_a(input int s, input int p, input bit need_grant);
    int n;
    n = 0;
    while (!(ka >= 0 && sa == s && pa == p && (!need_grant || ga[sa])) && n < 64) begin
      step();
      n++;
    end
    chk("wait_a_timeout", (n < 64) ? 1 : 0, 1);
  endtask

  initial begin
    // reset held: everything quiet
    steps(3);
    reset = 1'b0;
    steps(40);

    // request sampling: late rise is ignored this visit, honoured next one
    req_a = 2'b01;
    wait_a(1, 3, 0);
    req_a = 2'b11;
    steps(20);
    // dropping req mid-strobe does not truncate the strobe
    wait_a(1, 4, 1);
    req_a = 2'b01;
    steps(20);
    req_a = 2'b11;

    // I/O qualifier: high only around the slot-0 entry edge
    wait_a(1, 7, 0);
    cpu_io_hit = 1'b1;
    step();
    cpu_io_hit = 1'b0;
    steps(20);

    // randomized requests and I/O hits
    for (int i = 0; i < 400; i++) begin
      req_a = 2'($urandom);
      req_b = 4'($urandom);
      cpu_io_hit = ($urandom_range(0, 3) == 0);
      step();
    end
    req_a = 2'b11;
    req_b = 4'b1010;
    cpu_io_hit = 1'b0;
    steps(20);

    // reset in the middle of a granted channel-1 strobe
    wait_a(1, 3, 1);
    #2 reset = 1'b1;
    #1;
    ka = -1; kb = -1;
    compare();
    steps(3);
    reset = 1'b0;
    steps(40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_sequencer.md
Name: bus_sequencer

Overview:
- Parametrised successor to the fixed two-party bus timer.
- Divides each bus cycle into NUM_CHANNELS equal time slots of SLOT_CLKS clocks each. Channel 0 is the CPU; higher channels are other masters, e.g. Pi/SPI bridge or video fetch.
- Per slot: one-hot select, request-qualified strobe and a one-clock done pulse. An I/O qualifier applies to the CPU slot.
- Sits between the master request logic and the RAM/IO address/data muxes.

Parameters:
- NUM_CHANNELS, 2, number of slots per bus cycle (2..8); slot index = channel index.
- SLOT_CLKS, 8, clocks per slot; default gives 16 clocks/cycle, i.e. 1 MHz CPU at 16 MHz.
- STROBE_START, 2, phase within the slot at which strobe rises.
- STROBE_CLKS, 4, strobe width in clocks; must satisfy STROBE_START+STROBE_CLKS <= SLOT_CLKS and STROBE_CLKS >= 1. The constraint is checked at elaboration with a fatal error.

Ports:
- clk16  in  1  system clock, 16 MHz
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_CHANNELS  per-channel access request, level; channel 0 normally tied high
- cpu_io_hit  in  1  CPU address decodes to I/O space; sampled at CPU slot start
- select  out  NUM_CHANNELS  one-hot, high for the whole owning slot
- strobe  out  NUM_CHANNELS  read/write strobe, only for a granted slot
- done  out  NUM_CHANNELS  one-clock pulse on the last strobe clock of a granted slot
- io_select  out  1  CPU slot is an I/O access
- slot  out  $clog2(NUM_CHANNELS) (min 1)  current slot index
- cycle_start  out  1  one-clock pulse at phase 0 of slot 0

Behaviour:
- State:
  - phase counter 0..SLOT_CLKS-1 and slot counter 0..NUM_CHANNELS-1.
  - phase wraps to 0 and slot increments; slot NUM_CHANNELS-1 wraps to 0.
  - Free-running; no stall input.
- All outputs are registered and aligned with the counter state they describe.
- Reset, asynchronous:
  - counters go to 0.
  - select, strobe, done, io_select, cycle_start all 0; slot = 0.
- First edge after reset release:
  - enters slot 0 phase 0: select[0]=1, cycle_start=1.
  - no strobe yet.
- Grant:
  - At phase 0 of slot s, req[s] is sampled into grant_s.
  - req changes later in the slot are ignored until the next visit.
- strobe[s] = 1 for phases STROBE_START..STROBE_START+STROBE_CLKS-1 iff grant_s.
- done[s] = 1 only at phase STROBE_START+STROBE_CLKS-1 iff grant_s.
  - The requester drops req after done; re-asserting before the next visit is legal.
- Ungranted slot: select still asserted for the full slot; strobe and done stay 0.
- io_select:
  - cpu_io_hit sampled at slot 0 phase 0.
  - io_select = select[0] & sampled value; held for the whole CPU slot.
  - 0 in all other slots.
- Invariants:
  - select is always exactly one-hot after the first post-reset edge.
  - strobe is a subset of select.
  - at most one strobe and one done bit high per clock.
- Cycle length is always NUM_CHANNELS*SLOT_CLKS clocks; cycle_start period is exact.
- Reset mid-slot: all outputs drop asynchronously the same clock. Any in-flight strobe is truncated with no done pulse. Restart as above.
- Boundary: with STROBE_START+STROBE_CLKS = SLOT_CLKS, strobe and done end on the last phase. The next slot's select rises the following clock with no overlap.

Optional Feature:
- Macro BUS_SEQUENCER_CPU_CLK_EN.
- When defined, adds output port cpu_clk (1 bit, registered) as the CPU phi2:
  - 1 from slot 0 phase STROBE_START through slot 0 phase SLOT_CLKS-1.
  - 0 otherwise.
  - 0 during reset.
  - Generated regardless of req[0].
- When undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset/start, defaults, req=2'b11: release reset → cycle_start and select=01 on the first edge. select toggles 01/10 every 8 clocks; cycle_start every 16 clocks.
- Strobe timing, defaults, req=2'b11: strobe[0] high at slot-0 phases 2..5 and done[0] at phase 5. Same pattern for channel 1 at phases 10..13 from cycle start.
- Request sampling: req[1] rises at slot-1 phase 3 → no strobe[1] or done[1] that slot; strobe[1] appears next cycle. Dropping req[1] at phase 4 of a granted slot → strobe continues through phase 5 and done pulses.
- I/O qualifier: cpu_io_hit=1 at slot-0 phase 0 then 0 at phase 1 → io_select high for all 8 clocks of slot 0 and low in slot 1. cpu_io_hit=0 → io_select stays 0.
- Parametrised: NUM_CHANNELS=4, SLOT_CLKS=4, STROBE_START=1, STROBE_CLKS=3, req=4'b1010 → 16-clock cycle. select one-hot rotating 0..3; strobe only in slots 1 and 3 at phases 1..3; done at phase 3. Checked against a reference model every clock.
- Reset mid-strobe: assert reset at slot-1 phase 3 → strobe, select and done drop the same clock with no done pulse. Release → restart at slot 0. With BUS_SEQUENCER_CPU_CLK_EN, cpu_clk high for clocks 2..7 of each 16.
